// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: shared widths, writeback entry layout and write-port source
// encoding for the register-file write arbiter and its pending-write FIFO.
package regfile_pkg;

  localparam int REG_W   = 4;
  localparam int DATA_W  = 16;

  // "reg" is a reserved word, so the destination index field is regidx.
  typedef struct packed {
    logic [REG_W-1:0]  regidx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = REG_W + DATA_W;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LD,
    SRC_FIFO,
    SRC_ALU
  } wb_src_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// wb_fifo: in-order pending-write FIFO for ALU writebacks. Pointers carry one
// extra wrap bit so full/empty come straight from pointer comparison. The head
// is read combinationally so the arbiter can select it in the same cycle, and
// every slot is exported with an occupancy bit for the pending comparators.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [DEPTH*ENTRY_W-1:0]     entries_flat,
  output logic [DEPTH-1:0]             valid_vec
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t      r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_push;
  logic           w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count  = r_wr_ptr - r_rd_ptr;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointer advance; reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents need no reset because occupancy comes from pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is occupied when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] w_off;
      assign w_off = AW'(gi) - r_rd_ptr[AW-1:0];
      assign valid_vec[gi] = ({1'b0, w_off} < count);
      assign entries_flat[gi*ENTRY_W +: ENTRY_W] = r_mem[gi];
    end
  endgenerate

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges load and ALU writebacks onto the single
// register-file write port. Loads always win; ALU writes that cannot go
// straight through wait in wb_fifo and drain in order.
// Optional feature macro: PEND_LOOKUP_EN builds the src1_pend/src2_pend
// comparators; without it both are tied low and the read side must stall
// whenever pend_count is non-zero.
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [REG_W-1:0]           ld_reg,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_W-1:0]           alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  output logic [REG_W-1:0]           DstReg,
  output logic                       WriteReg,
  output logic [DATA_W-1:0]          DstData,
  input  logic [REG_W-1:0]           SrcReg1,
  input  logic [REG_W-1:0]           SrcReg2,
  output logic                       src1_pend,
  output logic                       src2_pend,
  output logic [$clog2(DEPTH+1)-1:0] pend_count
);

  import regfile_pkg::*;

  wb_src_e                    w_src;
  wb_entry_t                  w_alu_entry;
  wb_entry_t                  w_head;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [$clog2(DEPTH):0]     w_count;
  logic [DEPTH*ENTRY_W-1:0]   w_entries_flat;
  logic [DEPTH-1:0]           w_valid_vec;
  logic                       w_alu_fire;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_unused;

  logic [REG_W-1:0]           r_dst_reg;
  logic [DATA_W-1:0]          r_dst_data;
  logic                       r_write;

  // Loads are never stalled; ALU accepted while a FIFO slot is free.
  assign ld_ready    = !rst;
  assign alu_ready   = !rst && !w_fifo_full;
  assign w_alu_fire  = alu_valid && alu_ready;
  assign w_alu_entry = '{regidx: alu_reg, data: alu_data};

  // Write-port source priority: load, then queued ALU, then direct ALU.
  always_comb begin
    w_src = SRC_NONE;
    if (ld_valid)           w_src = SRC_LD;
    else if (!w_fifo_empty) w_src = SRC_FIFO;
    else if (alu_valid)     w_src = SRC_ALU;
  end

  // Any accepted ALU write that did not go straight to the port is queued.
  assign w_push = w_alu_fire && (w_src != SRC_ALU);
  assign w_pop  = (w_src == SRC_FIFO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (w_push),
    .push_entry   (w_alu_entry),
    .pop          (w_pop),
    .head         (w_head),
    .full         (w_fifo_full),
    .empty        (w_fifo_empty),
    .count        (w_count),
    .entries_flat (w_entries_flat),
    .valid_vec    (w_valid_vec)
  );

  assign pend_count = w_count;

  // Registered write port; idle cycles hold index/data and drop the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_reg  <= '0;
      r_dst_data <= '0;
      r_write    <= 1'b0;
    end else begin
      case (w_src)
        SRC_LD: begin
          r_dst_reg  <= ld_reg;
          r_dst_data <= ld_data;
          r_write    <= 1'b1;
        end
        SRC_FIFO: begin
          r_dst_reg  <= w_head.regidx;
          r_dst_data <= w_head.data;
          r_write    <= 1'b1;
        end
        SRC_ALU: begin
          r_dst_reg  <= alu_reg;
          r_dst_data <= alu_data;
          r_write    <= 1'b1;
        end
        default: r_write <= 1'b0;
      endcase
    end
  end

  assign DstReg   = r_dst_reg;
  assign DstData  = r_dst_data;
  assign WriteReg = r_write;

`ifdef PEND_LOOKUP_EN
  logic [DEPTH-1:0] w_match1;
  logic [DEPTH-1:0] w_match2;

  // Compare each occupied slot (including the one draining now) to both sources.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      wb_entry_t w_ent;
      assign w_ent        = w_entries_flat[gi*ENTRY_W +: ENTRY_W];
      assign w_match1[gi] = w_valid_vec[gi] && (w_ent.regidx == SrcReg1);
      assign w_match2[gi] = w_valid_vec[gi] && (w_ent.regidx == SrcReg2);
    end
  endgenerate

  assign src1_pend = |w_match1;
  assign src2_pend = |w_match2;
  assign w_unused  = ^w_entries_flat;
`else
  assign src1_pend = 1'b0;
  assign src2_pend = 1'b0;
  assign w_unused  = ^{SrcReg1, SrcReg2, w_entries_flat, w_valid_vec};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (DEPTH = 4): reset, lone ALU
// write, load/ALU collision, FIFO fill and in-order drain, mid-drain reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_reg;
  logic [15:0] ld_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic        src1_pend;
  logic        src2_pend;
  logic [2:0]  pend_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

`ifdef PEND_LOOKUP_EN
  localparam logic PEND_EXP = 1'b1;
`else
  localparam logic PEND_EXP = 1'b0;
`endif

  regfile_write_arbiter #(.DEPTH(4), .DATA_W(16), .REG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_reg     (ld_reg),
    .ld_data    (ld_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .DstReg     (DstReg),
    .WriteReg   (WriteReg),
    .DstData    (DstData),
    .SrcReg1    (SrcReg1),
    .SrcReg2    (SrcReg2),
    .src1_pend  (src1_pend),
    .src2_pend  (src2_pend),
    .pend_count (pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ld_valid = 0; ld_reg = 0; ld_data = 0;
    alu_valid = 0; alu_reg = 0; alu_data = 0; SrcReg1 = 0; SrcReg2 = 0;

    // Reset held for two cycles
    #1;
    check("rst_ld_ready", ld_ready, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_write", WriteReg, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle_write", WriteReg, 0);
    check("idle_dstreg", DstReg, 0);
    check("idle_dstdata", DstData, 0);
    check("idle_ld_ready", ld_ready, 1);
    check("idle_alu_ready", alu_ready, 1);
    check("idle_pend_count", pend_count, 0);
    check("idle_src1_pend", src1_pend, 0);

    // Lone ALU write goes direct
    alu_valid = 1; alu_reg = 4'd5; alu_data = 16'h1234; SrcReg1 = 4'd5;
    #1;
    check("alu_ready_lone", alu_ready, 1);
    tick();
    alu_valid = 0;
    #1;
    check("lone_write", WriteReg, 1);
    check("lone_dstreg", DstReg, 5);
    check("lone_dstdata", DstData, 16'h1234);
    check("lone_pend_count", pend_count, 0);
    check("lone_src1_pend", src1_pend, 0);
    tick();
    check("after_lone_write", WriteReg, 0);
    check("after_lone_hold_reg", DstReg, 5);
    check("after_lone_hold_data", DstData, 16'h1234);

    // Collision: load first, ALU queued then drained
    ld_valid = 1; ld_reg = 4'd3; ld_data = 16'hAAAA;
    alu_valid = 1; alu_reg = 4'd3; alu_data = 16'h5555;
    SrcReg1 = 4'd3; SrcReg2 = 4'd7;
    #1;
    check("coll_pend_before", pend_count, 0);
    tick();
    ld_valid = 0; alu_valid = 0;
    #1;
    check("coll_n1_write", WriteReg, 1);
    check("coll_n1_reg", DstReg, 3);
    check("coll_n1_data", DstData, 16'hAAAA);
    check("coll_n1_pend_count", pend_count, 1);
    check("coll_n1_src1_pend", src1_pend, PEND_EXP);
    check("coll_n1_src2_pend", src2_pend, 0);
    tick();
    check("coll_n2_write", WriteReg, 1);
    check("coll_n2_reg", DstReg, 3);
    check("coll_n2_data", DstData, 16'h5555);
    check("coll_n2_pend_count", pend_count, 0);
    check("coll_n2_src1_pend", src1_pend, 0);
    tick();
    check("coll_n3_write", WriteReg, 0);

    // Fill: six collision cycles, only four ALU entries fit
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1; ld_reg = 4'(i); ld_data = 16'h0100 + 16'(i);
      alu_valid = 1; alu_reg = 4'(8 + i); alu_data = 16'h0200 + 16'(i);
      #1;
      check($sformatf("fill%0d_alu_ready", i), alu_ready, (i < 4) ? 1 : 0);
      check($sformatf("fill%0d_pend_count", i), pend_count, (i < 4) ? i : 4);
      tick();
      check($sformatf("fill%0d_write", i), WriteReg, 1);
      check($sformatf("fill%0d_reg", i), DstReg, i);
      check($sformatf("fill%0d_data", i), DstData, 32'h0100 + i);
    end
    ld_valid = 0; alu_valid = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("drain%0d_pend_count", k), pend_count, 4 - k);
      tick();
      check($sformatf("drain%0d_write", k), WriteReg, 1);
      check($sformatf("drain%0d_reg", k), DstReg, 8 + k);
      check($sformatf("drain%0d_data", k), DstData, 32'h0200 + k);
    end
    #1;
    check("drain_done_pend", pend_count, 0);
    check("drain_done_alu_ready", alu_ready, 1);
    tick();
    check("drain_done_write", WriteReg, 0);

    // Mid-drain reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_reg = 4'd1; ld_data = 16'hC000 + 16'(i);
      alu_valid = 1; alu_reg = 4'd2; alu_data = 16'hD000 + 16'(i);
      tick();
    end
    ld_valid = 0; alu_valid = 0;
    #1;
    check("mid_pend_count", pend_count, 3);
    check("mid_write_before", WriteReg, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_write", WriteReg, 0);
    check("mid_rst_pend_count", pend_count, 0);
    check("mid_rst_alu_ready", alu_ready, 0);
    check("mid_rst_dstreg", DstReg, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst%0d_write", k), WriteReg, 0);
      check($sformatf("post_rst%0d_pend", k), pend_count, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-side front end for the 16x16 register file. It merges register writebacks from two producers, the ALU result path and the load-return path, onto the file's single write port (DstReg / WriteReg / DstData). ALU writes that collide with a load, or that queue behind earlier ALU writes, are buffered in a small in-order FIFO. Optional pending-write lookup tells the read side that a source register still has a queued write.

## Interface
Parameters:
- DEPTH, 4: ALU pending-write FIFO entries; power of 2, at least 2.
- DATA_W, 16: register data width.
- REG_W, 4: register index width.

Ports (all widths in bits):
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- ld_valid, in, 1: load writeback request.
- ld_ready, out, 1: load accepted.
- ld_reg, in, REG_W: load destination register.
- ld_data, in, DATA_W: load data.
- alu_valid, in, 1: ALU writeback request.
- alu_ready, out, 1: ALU request accepted.
- alu_reg, in, REG_W: ALU destination register.
- alu_data, in, DATA_W: ALU data.
- DstReg, out, REG_W: register file write index (registered).
- WriteReg, out, 1: register file write enable (registered).
- DstData, out, DATA_W: register file write data (registered).
- SrcReg1, in, REG_W: read-port-1 index, used for pending lookup.
- SrcReg2, in, REG_W: read-port-2 index, used for pending lookup.
- src1_pend, out, 1: SrcReg1 matches a queued FIFO entry.
- src2_pend, out, 1: SrcReg2 matches a queued FIFO entry.
- pend_count, out, $clog2(DEPTH+1): number of occupied FIFO entries.

## Operation
- **Handshakes.** A transfer occurs on valid && ready in the same cycle.
  - ld_ready = 1 whenever rst is low. Loads are never stalled.
  - alu_ready = (pend_count < DEPTH).
- **Write-port source selection**, evaluated every cycle in this priority order:
  1. Load, if ld_valid.
  2. FIFO head, if the FIFO is non-empty.
  3. ALU direct, if alu_valid and the FIFO is empty.
- **ALU routing.** An accepted ALU request is enqueued unless it was selected as "ALU direct".
- **Ordering.** When ld_valid and alu_valid are asserted in the same cycle, the load is the older instruction and is written first. ALU entries drain strictly in order.
  - Consequence: a load and an ALU write to the same register in the same cycle leave the ALU value in that register.
- **FIFO updates.**
  - Enqueue and dequeue in the same cycle leave pend_count unchanged.
  - On a full FIFO, alu_ready = 0. A load still writes that cycle, and the FIFO does not drain in that cycle.
- **Pending lookup.** src1_pend / src2_pend are combinational: OR over occupied entries of (entry.reg == SrcRegN). The entry being dequeued in the current cycle still counts as pending.
- **Idle cycle.** With no source selected, WriteReg = 0 next cycle and DstReg / DstData hold their last values.
- **No special registers.** Register 0 is not treated specially.

## Timing
- **Latency.**
  - A load or ALU-direct request accepted in cycle N appears on DstReg / DstData with WriteReg = 1 in cycle N+1.
  - A queued entry appears one cycle after it is selected as FIFO head.
- **Throughput.** One register write per cycle. Sustained two-producer traffic fills the FIFO at one entry per collision cycle.
- **Reset values**, asserted asynchronously:
  - DstReg = 0, DstData = 0, WriteReg = 0.
  - ld_ready = 0, alu_ready = 0.
  - pend_count = 0, src1_pend = 0, src2_pend = 0.
  - FIFO pointers are cleared.
- **Reset mid-operation.** Queued writes are discarded. A write already presented in the reset cycle is dropped because WriteReg is forced to 0 immediately.
- **Pointer wrap.** Read and write pointers carry REG-free wrap bits ($clog2(DEPTH)+1 bits). Full and empty are derived from pointer equality, with the MSB differing for full and matching for empty.

## Configuration
- **PEND_LOOKUP_EN defined:** the src1_pend / src2_pend comparators are built as described in Operation.
- **PEND_LOOKUP_EN undefined:**
  - src1_pend and src2_pend are tied to 0, and SrcReg1 / SrcReg2 are unused.
  - All other behaviour is identical.
  - The pipeline must then stall on any non-zero pend_count.

## Structure
- **Package regfile_pkg** holds:
  - REG_W = 4 and DATA_W = 16 constants.
  - wb_entry_t packed struct {reg[REG_W], data[DATA_W]}.
  - wb_src_e enum {SRC_NONE, SRC_LD, SRC_FIFO, SRC_ALU}.
- **Sub-module wb_fifo** (synchronous, DEPTH-parameterized) stores wb_entry_t and exposes:
  - push, pop, full, empty, count.
  - A flattened entry/valid vector for the pending comparators.
- **Top level** contains the source-select logic and the registered write-port outputs.

## Test plan
- **Reset then idle.** Hold rst for 2 cycles; release with no valid asserted → all outputs 0, ld_ready = 1, alu_ready = 1.
- **Lone ALU write.** alu_valid, alu_reg = 5, alu_data = 0x1234 in cycle N → cycle N+1 shows WriteReg = 1, DstReg = 5, DstData = 0x1234; pend_count stays 0.
- **Collision.** ld (reg 3, 0xAAAA) and alu (reg 3, 0x5555) in the same cycle N →
  - N+1: R3 ← 0xAAAA.
  - N+2: R3 ← 0x5555.
  - pend_count = 1 during N+1; src1_pend = 1 during N+1 when SrcReg1 = 3.
- **Fill.** With DEPTH = 4, drive ld_valid and alu_valid every cycle for 6 cycles →
  - alu_ready drops after 4 enqueues.
  - Loads are written every cycle.
  - After ld_valid drops, 4 queued ALU writes drain in order on consecutive cycles.
- **Mid-drain reset.** Assert rst asynchronously mid-cycle while pend_count = 3 → WriteReg falls immediately, pend_count = 0; after release, no stale writes appear.
- **Macro off.** Build without PEND_LOOKUP_EN and rerun the collision scenario → src1_pend stays 0; write sequence is unchanged.
